instr_sequencer: RTL

//   Front-end controller between the rx FIFO and the execution units (unified buffer, PE array,

---
 rtl/instr_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Brief    : Byte-stream instruction fetch/decode/issue controller with
//            valid/ready command handshake, halt, and error handling.
// Revision : 1.0  initial release
// ============================================================================
module instr_sequencer #(
    parameter int FIFO_DATA_WIDTH  = 8,
    parameter int BUFFER_WORD_SIZE = 16,
    parameter int OPCODE_WIDTH     = 3,
    parameter int ADDRESS_SIZE     = 9,
    parameter int DONE_TIMEOUT     = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        rx_empty,
    input  logic [FIFO_DATA_WIDTH-1:0]  rx_data,
    output logic                        rx_re,
    output logic                        cmd_valid,
    input  logic                        cmd_ready,
    output logic [OPCODE_WIDTH-1:0]     cmd_op,
    output logic [2:0]                  cmd_flags,
    output logic [ADDRESS_SIZE-1:0]     cmd_addr,
    output logic [BUFFER_WORD_SIZE-1:0] cmd_data,
    input  logic                        op_done,
    output logic                        busy,
    output logic                        halted,
    output logic                        err,
    output logic [1:0]                  err_code,
    output logic [15:0]                 instr_count
);

    localparam int c_TW = $clog2(DONE_TIMEOUT + 1);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(DONE_TIMEOUT - 1);

    localparam logic [3:0] c_ST_IDLE      = 4'd0;
    localparam logic [3:0] c_ST_FETCH_LO  = 4'd1;
    localparam logic [3:0] c_ST_FETCH_HI  = 4'd2;
    localparam logic [3:0] c_ST_DECODE    = 4'd3;
    localparam logic [3:0] c_ST_DATA_LO   = 4'd4;
    localparam logic [3:0] c_ST_DATA_HI   = 4'd5;
    localparam logic [3:0] c_ST_ISSUE     = 4'd6;
    localparam logic [3:0] c_ST_WAIT_DONE = 4'd7;
    localparam logic [3:0] c_ST_HALT      = 4'd8;
    localparam logic [3:0] c_ST_ERROR     = 4'd9;

    localparam logic [OPCODE_WIDTH-1:0] c_OP_STORE = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_FETCH = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_RUN   = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_LOAD  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_HALT  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_NOP   = OPCODE_WIDTH'(5);

    logic [3:0]                  r_state;
    logic [3:0]                  w_next;
    logic [BUFFER_WORD_SIZE-1:0] r_instr;
    logic [BUFFER_WORD_SIZE-1:0] r_data;
    logic [15:0]                 r_count;
    logic [c_TW-1:0]             r_tmo;
    logic [1:0]                  r_err_code;

    logic [OPCODE_WIDTH-1:0]     w_op;
    logic [2:0]                  w_flags;
    logic [ADDRESS_SIZE-1:0]     w_addr;
    logic                        w_is_cmd;
    logic                        w_timeout;
    logic                        w_unused_bits;

    assign w_op      = r_instr[OPCODE_WIDTH-1:0];
    assign w_flags   = r_instr[OPCODE_WIDTH+2:OPCODE_WIDTH];
    assign w_addr    = r_instr[BUFFER_WORD_SIZE-1 -: ADDRESS_SIZE];
    assign w_is_cmd  = (w_op == c_OP_FETCH) || (w_op == c_OP_RUN) || (w_op == c_OP_LOAD);
    assign w_timeout = !op_done && (r_tmo == c_TMO_LAST);
    // The bits between the flags and address fields carry no meaning.
    assign w_unused_bits = ^r_instr[BUFFER_WORD_SIZE-ADDRESS_SIZE-1:OPCODE_WIDTH+3];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE:     if (start) w_next = c_ST_FETCH_LO;
            c_ST_FETCH_LO: if (!rx_empty) w_next = c_ST_FETCH_HI;
            c_ST_FETCH_HI: if (!rx_empty) w_next = c_ST_DECODE;
            c_ST_DECODE: begin
                if (w_op == c_OP_STORE)     w_next = c_ST_DATA_LO;
                else if (w_is_cmd)          w_next = c_ST_ISSUE;
                else if (w_op == c_OP_HALT) w_next = c_ST_HALT;
                else if (w_op == c_OP_NOP)  w_next = c_ST_FETCH_LO;
                else                        w_next = c_ST_ERROR;
            end
            c_ST_DATA_LO:  if (!rx_empty) w_next = c_ST_DATA_HI;
            c_ST_DATA_HI:  if (!rx_empty) w_next = c_ST_ISSUE;
            c_ST_ISSUE:    if (cmd_ready) w_next = c_ST_WAIT_DONE;
            c_ST_WAIT_DONE: begin
                if (op_done)        w_next = c_ST_FETCH_LO;
                else if (w_timeout) w_next = c_ST_ERROR;
            end
            c_ST_HALT:     if (start) w_next = c_ST_FETCH_LO;
            c_ST_ERROR:    w_next = c_ST_ERROR;
            default:       w_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        rx_re     = 1'b0;
        cmd_valid = 1'b0;
        busy      = 1'b1;
        halted    = 1'b0;
        err       = 1'b0;
        cmd_op    = '0;
        cmd_flags = '0;
        cmd_addr  = '0;
        cmd_data  = '0;
        case (r_state)
            c_ST_IDLE: busy = 1'b0;
            c_ST_FETCH_LO, c_ST_FETCH_HI, c_ST_DATA_LO, c_ST_DATA_HI: rx_re = !rx_empty;
            c_ST_ISSUE: begin
                cmd_valid = 1'b1;
                cmd_op    = w_op;
                cmd_flags = w_flags;
                cmd_addr  = w_addr;
                if (w_op == c_OP_STORE) cmd_data = r_data;
            end
            c_ST_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            c_ST_ERROR: begin
                busy = 1'b0;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

    assign err_code    = r_err_code;
    assign instr_count = r_count;

    // Bytes land on the same edge that pops them; partial words survive FIFO stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_instr    <= '0;
            r_data     <= '0;
            r_count    <= '0;
            r_tmo      <= '0;
            r_err_code <= '0;
        end else begin
            if (rx_re) begin
                case (r_state)
                    c_ST_FETCH_LO: r_instr[FIFO_DATA_WIDTH-1:0] <= rx_data;
                    c_ST_FETCH_HI: r_instr[BUFFER_WORD_SIZE-1:FIFO_DATA_WIDTH] <= rx_data;
                    c_ST_DATA_LO:  r_data[FIFO_DATA_WIDTH-1:0] <= rx_data;
                    c_ST_DATA_HI:  r_data[BUFFER_WORD_SIZE-1:FIFO_DATA_WIDTH] <= rx_data;
                    default: ;
                endcase
            end

            if (r_state == c_ST_WAIT_DONE && !op_done) begin
                r_tmo <= r_tmo + c_TW'(1);
            end else begin
                r_tmo <= '0;
            end

            if ((r_state == c_ST_DECODE && w_op == c_OP_NOP) ||
                (r_state == c_ST_WAIT_DONE && op_done)) begin
                r_count <= r_count + 16'd1;
            end

            if (r_state == c_ST_DECODE && w_op > c_OP_NOP) begin
                r_err_code <= 2'd1;
            end else if (r_state == c_ST_WAIT_DONE && w_timeout) begin
                r_err_code <= 2'd2;
            end
        end
    end

endmodule
`default_nettype wire
